// File: rtl/round_robin_arbiter_4.sv
// Four-way round-robin arbiter with a bounded hold time and one idle cycle
// between owners; all outputs come straight from registers.
module round_robin_arbiter_4 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] grant,
   output logic [1:0] grant_idx,
   output logic       grant_valid
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q;
   logic [3:0] grant_q;
   logic [1:0] grant_idx_q;
   logic       grant_valid_q;
   logic [1:0] last_idx_q;
   logic [7:0] hold_cnt_q;

   logic [7:0] hold_cnt_d;
   logic [1:0] cand_idx [4];
   logic [3:0] cand_hit;
   logic [1:0] win_idx_d;
   logic       owner_req;
   logic       others_req;
   logic       hold_expired;
   logic       release_now;

   // Candidate gi is the (gi+1)-th requester after the previous winner.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cand
         assign cand_idx[gi] = last_idx_q + 2'(gi + 1);
         assign cand_hit[gi] = req[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      win_idx_d = cand_idx[3];
      for (int i = 3; i >= 0; i--) begin
         if (cand_hit[i]) begin
            win_idx_d = cand_idx[i];
         end
      end
   end

   assign owner_req    = req[grant_idx_q];
   assign others_req   = |(req & ~grant_q);
   assign hold_expired = (hold_cnt_q >= 8'(MAX_HOLD));
   assign release_now  = !owner_req || (hold_expired && others_req);
   assign hold_cnt_d   = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         grant_q       <= 4'b0000;
         grant_idx_q   <= 2'b00;
         grant_valid_q <= 1'b0;
         hold_cnt_q    <= 8'd0;
         last_idx_q    <= 2'b11;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  state_q       <= GRANT;
                  grant_q       <= 4'b0001 << win_idx_d;
                  grant_idx_q   <= win_idx_d;
                  grant_valid_q <= 1'b1;
                  hold_cnt_q    <= 8'd1;
                  last_idx_q    <= win_idx_d;
               end
            end
            GRANT: begin
               // Releasing always passes through IDLE, giving the idle gap.
               if (release_now) begin
                  state_q       <= IDLE;
                  grant_q       <= 4'b0000;
                  grant_idx_q   <= 2'b00;
                  grant_valid_q <= 1'b0;
                  hold_cnt_q    <= 8'd0;
               end else begin
                  hold_cnt_q <= hold_cnt_d;
               end
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;

endmodule
